// File: rtl/sfifo_emu_if.sv
// ---------------------------------------------------------------------------
// sfifo_emu_if
//
// Purpose:
//   Bundles the IFCLK slave-FIFO bus and the emulated USB "host" FIFO port
//   of the sfifo_emu block. The clock and reset are kept outside as plain
//   ports of the modules that use this interface.
//
// Signals (direction seen from the slave, i.e. the emulated controller):
//   FIFOADR        in   2   endpoint select {FIFOADR1,FIFOADR0}
//   SLOE           in   1   active-low output enable
//   SLRD           in   1   active-low read strobe
//   SLWR           in   1   active-low write strobe
//   PKTEND         in   1   active-low packet end
//   FIFO_DATA_IN   in  16   data written by the FPGA master (IN endpoint)
//   FIFO_DATA_OUT  out 16   data read by the FPGA master (OUT endpoint)
//   FIFO_DATA_OE   out  1   FIFO_DATA_OUT is being driven
//   FLAGB          out  1   IN endpoint not full
//   FLAGC          out  1   OUT endpoint not empty
//   host_din       in  16   host word pushed into the OUT buffer
//   host_wr_en     in   1   push host_din
//   host_full      out  1   OUT buffer full
//   host_dout      out 16   head committed IN word (first-word fall-through)
//   host_last      out  1   host_dout closes its packet
//   host_rd_en     in   1   pop committed IN word
//   host_empty     out  1   no committed IN words
//   proto_error    out  4   sticky protocol error bits
//
// Modports:
//   master - FPGA master plus host model (drives strobes and host requests)
//   slave  - the emulated controller
// ---------------------------------------------------------------------------
interface sfifo_emu_if;
    logic [1:0]  FIFOADR;
    logic        SLOE;
    logic        SLRD;
    logic        SLWR;
    logic        PKTEND;
    logic [15:0] FIFO_DATA_IN;
    logic [15:0] FIFO_DATA_OUT;
    logic        FIFO_DATA_OE;
    logic        FLAGB;
    logic        FLAGC;
    logic [15:0] host_din;
    logic        host_wr_en;
    logic        host_full;
    logic [15:0] host_dout;
    logic        host_last;
    logic        host_rd_en;
    logic        host_empty;
    logic [3:0]  proto_error;

    modport master (
        output FIFOADR, SLOE, SLRD, SLWR, PKTEND, FIFO_DATA_IN,
        output host_din, host_wr_en, host_rd_en,
        input  FIFO_DATA_OUT, FIFO_DATA_OE, FLAGB, FLAGC,
        input  host_full, host_dout, host_last, host_empty, proto_error
    );

    modport slave (
        input  FIFOADR, SLOE, SLRD, SLWR, PKTEND, FIFO_DATA_IN,
        input  host_din, host_wr_en, host_rd_en,
        output FIFO_DATA_OUT, FIFO_DATA_OE, FLAGB, FLAGC,
        output host_full, host_dout, host_last, host_empty, proto_error
    );
endinterface

// File: rtl/sfifo_emu.sv
// ---------------------------------------------------------------------------
// sfifo_emu
//
// Purpose:
//   Synthesizable emulation of a USB device controller's Slave FIFO, seen
//   from the FPGA side of the IFCLK bus. It holds one OUT endpoint buffer
//   (host -> FPGA, filled through the host_* write port) and one packetized
//   IN endpoint buffer (FPGA -> host, drained through the host_* read port).
//   Words written on the bus stay uncommitted until PKT_WORDS have been
//   collected or PKTEND closes the packet; only committed words are visible
//   to the host. Used for on-chip loopback and as a bench partner for the
//   high-speed I/O block.
//
// Ports:
//   IFCLK   in  sole clock, all logic on the rising edge
//   RESET   in  synchronous, active-high; discards all buffered data
//   bus     sfifo_emu_if.slave (slave-FIFO bus plus host FIFO port)
//
// proto_error bits (sticky until RESET):
//   [0] SLRD on the OUT endpoint while it is empty
//   [1] SLWR on the IN endpoint while it is full
//   [2] SLRD with the OUT endpoint not selected or with SLOE high
//   [3] SLWR and SLRD in the same cycle
//   An erroneous strobe leaves the buffers untouched.
//
// Build option:
//   SFIFO_EMU_FLAG_DELAY_EN - when defined, FLAGB/FLAGC get one extra
//   register stage (2-cycle latency) to mimic the real controller's flag
//   lag. Error detection and buffer protection always use the true state.
// ---------------------------------------------------------------------------
module sfifo_emu #(
    parameter int USB_ENDPOINT_IN  = 2,
    parameter int USB_ENDPOINT_OUT = 6,
    parameter int OUT_DEPTH_LOG2   = 9,
    parameter int IN_DEPTH_LOG2    = 9,
    parameter int PKT_WORDS        = 256   // must not exceed 2**IN_DEPTH_LOG2
) (
    input  logic       IFCLK,
    input  logic       RESET,
    sfifo_emu_if.slave bus
);

    localparam int DATA_W = 16;

    localparam int OUT_AW = OUT_DEPTH_LOG2;
    localparam int OUT_CW = OUT_DEPTH_LOG2 + 1;
    localparam int IN_AW  = IN_DEPTH_LOG2;
    localparam int IN_CW  = IN_DEPTH_LOG2 + 1;

    localparam int OUT_DEPTH = 1 << OUT_DEPTH_LOG2;
    localparam int IN_DEPTH  = 1 << IN_DEPTH_LOG2;

    localparam logic [OUT_CW-1:0] OUT_FULL = OUT_CW'(OUT_DEPTH);
    localparam logic [IN_CW-1:0]  IN_FULL  = IN_CW'(IN_DEPTH);
    localparam logic [IN_CW-1:0]  PKT_CNT  = IN_CW'(PKT_WORDS);

    localparam logic [1:0] OUT_CODE = 2'((USB_ENDPOINT_OUT - 2) >> 1);
    localparam logic [1:0] IN_CODE  = 2'((USB_ENDPOINT_IN - 2) >> 1);

    // Storage (no reset: contents are only meaningful behind the pointers)
    logic [DATA_W-1:0] out_mem [0:OUT_DEPTH-1];
    logic [DATA_W-1:0] in_mem  [0:IN_DEPTH-1];
    logic              in_last [0:IN_DEPTH-1];

    // Control state
    logic [OUT_AW-1:0] out_wr_ptr;
    logic [OUT_AW-1:0] out_rd_ptr;
    logic [OUT_CW-1:0] out_count;
    logic [IN_AW-1:0]  in_wr_ptr;
    logic [IN_AW-1:0]  in_rd_ptr;
    logic [IN_CW-1:0]  in_com_count;   // committed, visible to the host
    logic [IN_CW-1:0]  in_unc_count;   // written but not yet committed
    logic [3:0]        err_sticky;
    logic              flagb_p0;
    logic              flagc_p0;

    // Decode and strobe qualification
    logic              out_sel;
    logic              in_sel;
    logic              rd_strobe;
    logic              wr_strobe;
    logic              pkt_end;
    logic              out_empty;
    logic              out_is_full;
    logic              in_space;
    logic [IN_CW-1:0]  in_total;
    logic              out_push;
    logic              out_pop;
    logic              in_wr;
    logic              in_pop;
    logic              commit;
    logic [IN_CW-1:0]  unc_plus;
    logic [IN_CW-1:0]  com_nxt;
    logic [IN_CW-1:0]  unc_nxt;
    logic [IN_CW-1:0]  total_nxt;
    logic [OUT_CW-1:0] out_count_nxt;
    logic [IN_AW-1:0]  in_prev_ptr;
    logic [3:0]        err_now;

    assign out_sel   = (bus.FIFOADR == OUT_CODE);
    assign in_sel    = (bus.FIFOADR == IN_CODE);
    assign rd_strobe = !bus.SLRD;
    assign wr_strobe = !bus.SLWR;
    assign pkt_end   = !bus.PKTEND && in_sel;

    assign out_empty   = (out_count == '0);
    assign out_is_full = (out_count == OUT_FULL);
    assign in_total    = in_com_count + in_unc_count;
    assign in_space    = (in_total != IN_FULL);

    assign err_now[0] = rd_strobe && out_sel && out_empty;
    assign err_now[1] = wr_strobe && in_sel && !in_space;
    assign err_now[2] = rd_strobe && (!out_sel || bus.SLOE);
    assign err_now[3] = rd_strobe && wr_strobe;

    // A strobe only acts when it is legal; simultaneous SLRD/SLWR is
    // rejected as a whole so neither buffer moves.
    assign out_pop  = rd_strobe && out_sel && !bus.SLOE && !out_empty && !wr_strobe;
    assign out_push = bus.host_wr_en && !out_is_full;
    assign in_wr    = wr_strobe && in_sel && in_space && !rd_strobe;
    assign in_pop   = bus.host_rd_en && (in_com_count != '0);

    // The packet closes either on reaching PKT_WORDS or on PKTEND; a PKTEND
    // with nothing pending (zero-length packet) commits nothing.
    assign unc_plus = in_unc_count + IN_CW'(in_wr);
    assign commit   = (in_wr && (unc_plus == PKT_CNT)) ||
                      (pkt_end && (unc_plus != '0));

    assign com_nxt       = in_com_count - IN_CW'(in_pop) + (commit ? unc_plus : '0);
    assign unc_nxt       = commit ? '0 : unc_plus;
    assign total_nxt     = com_nxt + unc_nxt;
    assign out_count_nxt = out_count + OUT_CW'(out_push) - OUT_CW'(out_pop);
    assign in_prev_ptr   = in_wr_ptr - IN_AW'(1);

    // Buffer storage writes. A PKTEND without a same-cycle write marks the
    // most recently written word as the packet's last one.
    always_ff @(posedge IFCLK) begin
        if (out_push) begin
            out_mem[out_wr_ptr] <= bus.host_din;
        end
        if (in_wr) begin
            in_mem[in_wr_ptr]  <= bus.FIFO_DATA_IN;
            in_last[in_wr_ptr] <= commit;
        end else if (commit) begin
            in_last[in_prev_ptr] <= 1'b1;
        end
    end

    // Stage p0: pointers, counts, sticky errors and first flag register
    always_ff @(posedge IFCLK) begin
        if (RESET) begin
            out_wr_ptr   <= '0;
            out_rd_ptr   <= '0;
            out_count    <= '0;
            in_wr_ptr    <= '0;
            in_rd_ptr    <= '0;
            in_com_count <= '0;
            in_unc_count <= '0;
            err_sticky   <= '0;
            flagb_p0     <= 1'b1;
            flagc_p0     <= 1'b0;
        end else begin
            out_wr_ptr   <= out_wr_ptr + OUT_AW'(out_push);
            out_rd_ptr   <= out_rd_ptr + OUT_AW'(out_pop);
            out_count    <= out_count_nxt;
            in_wr_ptr    <= in_wr_ptr + IN_AW'(in_wr);
            in_rd_ptr    <= in_rd_ptr + IN_AW'(in_pop);
            in_com_count <= com_nxt;
            in_unc_count <= unc_nxt;
            err_sticky   <= err_sticky | err_now;
            flagb_p0     <= (total_nxt != IN_FULL);
            flagc_p0     <= (out_count_nxt != '0);
        end
    end

`ifdef SFIFO_EMU_FLAG_DELAY_EN
    logic flagb_p1;
    logic flagc_p1;

    // Stage p1: extra flag lag to match the real controller
    always_ff @(posedge IFCLK) begin
        if (RESET) begin
            flagb_p1 <= 1'b1;
            flagc_p1 <= 1'b0;
        end else begin
            flagb_p1 <= flagb_p0;
            flagc_p1 <= flagc_p0;
        end
    end

    assign bus.FLAGB = flagb_p1;
    assign bus.FLAGC = flagc_p1;
`else
    assign bus.FLAGB = flagb_p0;
    assign bus.FLAGC = flagc_p0;
`endif

    // Bus read side is combinational from the registered read pointer
    assign bus.FIFO_DATA_OE  = !bus.SLOE && out_sel;
    assign bus.FIFO_DATA_OUT = bus.FIFO_DATA_OE ? out_mem[out_rd_ptr] : '0;

    assign bus.host_full   = out_is_full;
    assign bus.host_empty  = (in_com_count == '0);
    assign bus.host_dout   = in_mem[in_rd_ptr];
    assign bus.host_last   = in_last[in_rd_ptr];
    assign bus.proto_error = err_sticky;

endmodule

// File: tb/tb_sfifo_emu.sv
// ---------------------------------------------------------------------------
// tb_sfifo_emu
//
// Directed bench for sfifo_emu (default build, 1-cycle flag latency).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
// the inputs settle, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_sfifo_emu;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    sfifo_emu_if bus ();

    sfifo_emu dut (
        .IFCLK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst              = 1'b1;
        bus.FIFOADR      = 2'b11;
        bus.SLOE         = 1'b1;
        bus.SLRD         = 1'b1;
        bus.SLWR         = 1'b1;
        bus.PKTEND       = 1'b1;
        bus.FIFO_DATA_IN = 16'h0000;
        bus.host_din     = 16'h0000;
        bus.host_wr_en   = 1'b0;
        bus.host_rd_en   = 1'b0;

        // Reset state
        repeat (3) tick();
        #1;
        check("rst_flagb", bus.FLAGB, 1);
        check("rst_flagc", bus.FLAGC, 0);
        check("rst_host_full", bus.host_full, 0);
        check("rst_host_empty", bus.host_empty, 1);
        check("rst_oe", bus.FIFO_DATA_OE, 0);
        check("rst_dout", bus.FIFO_DATA_OUT, 0);
        check("rst_perr", bus.proto_error, 0);
        rst = 1'b0;

        // OUT path: host writes three words, master reads them back-to-back
        bus.host_wr_en = 1'b1;
        bus.host_din = 16'h1111; tick();
        bus.host_din = 16'h2222; tick();
        bus.host_din = 16'h3333; tick();
        bus.host_wr_en = 1'b0;
        #1;
        check("out_flagc_set", bus.FLAGC, 1);
        bus.FIFOADR = 2'b10;
        bus.SLOE    = 1'b0;
        #1;
        check("out_oe", bus.FIFO_DATA_OE, 1);
        check("out_w0", bus.FIFO_DATA_OUT, 16'h1111);
        bus.SLRD = 1'b0;
        tick();
        check("out_w1", bus.FIFO_DATA_OUT, 16'h2222);
        check("out_flagc_mid", bus.FLAGC, 1);
        tick();
        check("out_w2", bus.FIFO_DATA_OUT, 16'h3333);
        tick();
        bus.SLRD = 1'b1;
        #1;
        check("out_flagc_clr", bus.FLAGC, 0);
        check("out_perr", bus.proto_error, 0);
        bus.SLOE    = 1'b1;
        bus.FIFOADR = 2'b11;
        #1;
        check("out_oe_off", bus.FIFO_DATA_OE, 0);
        check("out_dout_off", bus.FIFO_DATA_OUT, 0);

        // IN path: one full 256-word auto-committed packet
        bus.FIFOADR = 2'b00;
        bus.SLWR    = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.FIFO_DATA_IN = 16'(i);
            if (i == 255) begin
                #1;
                check("pkt_empty_before", bus.host_empty, 1);
            end
            tick();
        end
        bus.SLWR = 1'b1;
        #1;
        check("pkt_empty_after", bus.host_empty, 0);
        check("pkt_flagb", bus.FLAGB, 1);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("pkt_d%0d", i), bus.host_dout, 32'(i));
            check($sformatf("pkt_l%0d", i), bus.host_last, (i == 255) ? 1 : 0);
            bus.host_rd_en = 1'b1;
            tick();
        end
        bus.host_rd_en = 1'b0;
        #1;
        check("pkt_drained", bus.host_empty, 1);

        // Short packet closed by PKTEND alone
        for (int i = 0; i < 5; i++) begin
            bus.FIFO_DATA_IN = 16'hA0 + 16'(i);
            bus.SLWR = 1'b0;
            tick();
        end
        bus.SLWR = 1'b1;
        #1;
        check("pe_uncommitted", bus.host_empty, 1);
        bus.PKTEND = 1'b0;
        tick();
        bus.PKTEND = 1'b1;
        #1;
        check("pe_committed", bus.host_empty, 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("pe_d%0d", i), bus.host_dout, 32'(16'hA0 + i));
            check($sformatf("pe_l%0d", i), bus.host_last, (i == 4) ? 1 : 0);
            bus.host_rd_en = 1'b1;
            tick();
        end
        bus.host_rd_en = 1'b0;
        #1;
        check("pe_drained", bus.host_empty, 1);

        // Short packet with PKTEND on the same edge as the 5th write
        for (int i = 0; i < 5; i++) begin
            bus.FIFO_DATA_IN = 16'hB0 + 16'(i);
            bus.SLWR = 1'b0;
            if (i == 4) bus.PKTEND = 1'b0;
            tick();
        end
        bus.SLWR   = 1'b1;
        bus.PKTEND = 1'b1;
        #1;
        check("pw_committed", bus.host_empty, 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("pw_d%0d", i), bus.host_dout, 32'(16'hB0 + i));
            check($sformatf("pw_l%0d", i), bus.host_last, (i == 4) ? 1 : 0);
            bus.host_rd_en = 1'b1;
            tick();
        end
        bus.host_rd_en = 1'b0;
        #1;
        check("pw_drained", bus.host_empty, 1);

        // Zero-length packet is ignored
        bus.PKTEND = 1'b0;
        tick();
        bus.PKTEND = 1'b1;
        #1;
        check("zlp_empty", bus.host_empty, 1);
        check("zlp_perr", bus.proto_error, 0);

        // Fill IN completely (two auto packets), overflow, then free one word
        bus.SLWR = 1'b0;
        for (int i = 0; i < 512; i++) begin
            bus.FIFO_DATA_IN = 16'(i) ^ 16'h5A5A;
            if (i == 511) begin
                #1;
                check("full_flagb_before", bus.FLAGB, 1);
            end
            tick();
        end
        bus.SLWR = 1'b1;
        #1;
        check("full_flagb", bus.FLAGB, 0);
        check("full_perr_clean", bus.proto_error, 0);
        bus.FIFO_DATA_IN = 16'hDEAD;
        bus.SLWR = 1'b0;
        tick();
        bus.SLWR = 1'b1;
        #1;
        check("ovf_perr", bus.proto_error, 4'b0010);
        check("ovf_flagb", bus.FLAGB, 0);
        check("ovf_head", bus.host_dout, 16'h5A5A);
        check("ovf_head_last", bus.host_last, 0);
        bus.host_rd_en = 1'b1;
        tick();
        bus.host_rd_en = 1'b0;
        #1;
        check("ovf_flagb_back", bus.FLAGB, 1);
        for (int i = 1; i < 512; i++) begin
            check($sformatf("fill_d%0d", i), bus.host_dout, 32'(16'(i) ^ 16'h5A5A));
            check($sformatf("fill_l%0d", i), bus.host_last, (i == 255 || i == 511) ? 1 : 0);
            bus.host_rd_en = 1'b1;
            tick();
        end
        bus.host_rd_en = 1'b0;
        #1;
        check("fill_drained", bus.host_empty, 1);

        // Protocol errors accumulate and stick
        bus.FIFOADR = 2'b10;
        bus.SLOE    = 1'b0;
        bus.SLRD    = 1'b0;
        tick();
        bus.SLRD = 1'b1;
        #1;
        check("err_rd_empty", bus.proto_error, 4'b0011);
        bus.FIFOADR = 2'b00;
        bus.SLRD    = 1'b0;
        tick();
        bus.SLRD = 1'b1;
        #1;
        check("err_rd_unsel", bus.proto_error, 4'b0111);
        bus.FIFO_DATA_IN = 16'hBEEF;
        bus.SLWR = 1'b0;
        bus.SLRD = 1'b0;
        tick();
        bus.SLWR   = 1'b1;
        bus.SLRD   = 1'b1;
        bus.PKTEND = 1'b0;
        tick();
        bus.PKTEND = 1'b1;
        bus.SLOE   = 1'b1;
        #1;
        check("err_both", bus.proto_error, 4'b1111);
        check("err_both_nowrite", bus.host_empty, 1);

        // OUT buffer full from the host side
        bus.host_wr_en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            bus.host_din = 16'h0100 + 16'(i);
            if (i == 511) begin
                #1;
                check("hfull_before", bus.host_full, 0);
            end
            tick();
        end
        check("hfull_set", bus.host_full, 1);
        bus.host_din = 16'hFFFF;
        tick();
        bus.host_wr_en = 1'b0;
        bus.FIFOADR = 2'b10;
        bus.SLOE    = 1'b0;
        #1;
        check("hfull_hold", bus.host_full, 1);
        check("hfull_flagc", bus.FLAGC, 1);
        check("hfull_head", bus.FIFO_DATA_OUT, 16'h0100);
        check("hfull_perr", bus.proto_error, 4'b1111);
        bus.SLOE = 1'b1;

        // Reset in the middle of an uncommitted packet, with SLWR still low
        bus.FIFOADR = 2'b00;
        bus.SLWR    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.FIFO_DATA_IN = 16'(i);
            tick();
        end
        check("mid_uncommitted", bus.host_empty, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.SLWR = 1'b1;
        #1;
        check("mid_rst_empty", bus.host_empty, 1);
        check("mid_rst_flagb", bus.FLAGB, 1);
        check("mid_rst_flagc", bus.FLAGC, 0);
        check("mid_rst_perr", bus.proto_error, 0);
        check("mid_rst_hfull", bus.host_full, 0);
        bus.PKTEND = 1'b0;
        tick();
        bus.PKTEND = 1'b1;
        #1;
        check("mid_rst_discard", bus.host_empty, 1);
        check("mid_rst_perr2", bus.proto_error, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sfifo_emu.md
Name: sfifo_emu

Overview:
- Synthesizable emulation of the USB device controller's Slave FIFO, i.e. the peripheral end of the IFCLK slave-FIFO bus.
- Responds to SLOE/SLRD/SLWR/PKTEND/FIFOADR exactly as the controller does, and drives FLAGB (not FULL) and FLAGC (not EMPTY).
- Holds one OUT endpoint buffer (host→FPGA) and one IN endpoint buffer (FPGA→host); the IN buffer is packetized.
- Used for on-chip loopback and for the testbench of the high-speed I/O block; a simple FIFO-style "host" port replaces the USB side.

Parameters:
- USB_ENDPOINT_IN, 2, IN endpoint number (host view); FIFOADR code = (EP-2)>>1.
- USB_ENDPOINT_OUT, 6, OUT endpoint number (host view); FIFOADR code = (EP-2)>>1.
- OUT_DEPTH_LOG2, 9, OUT buffer depth = 2^n 16-bit words.
- IN_DEPTH_LOG2, 9, IN buffer depth = 2^n words.
- PKT_WORDS, 256, IN packet auto-commit size in words; must be ≤ IN depth.

Ports:
- IFCLK  in  1  sole clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- FIFOADR  in  2  {FIFOADR1,FIFOADR0} endpoint select.
- SLOE  in  1  active-low output enable.
- SLRD  in  1  active-low read strobe.
- SLWR  in  1  active-low write strobe.
- PKTEND  in  1  active-low packet end.
- FIFO_DATA_IN  in  16  data from FPGA master (IN endpoint).
- FIFO_DATA_OUT  out  16  data to FPGA master (OUT endpoint).
- FIFO_DATA_OE  out  1  high when FIFO_DATA_OUT is driven.
- FLAGB  out  1  IN endpoint not full (high = space available).
- FLAGC  out  1  OUT endpoint not empty (high = data available).
- host_din  in  16  host word for OUT buffer.
- host_wr_en  in  1  push host_din.
- host_full  out  1  OUT buffer full.
- host_dout  out  16  head committed IN word (first-word fall-through).
- host_last  out  1  host_dout is the last word of its packet.
- host_rd_en  in  1  pop committed IN word.
- host_empty  out  1  no committed IN words.
- proto_error  out  4  sticky error bits (see below).

Behaviour:
- Reset state: all pointers 0; FLAGB=1; FLAGC=0; host_full=0; host_empty=1; FIFO_DATA_OE=0; proto_error=0. RESET dominates all same-cycle strobes. RESET mid-packet discards all buffered and uncommitted data.
- Address decode: OUT_SEL = (FIFOADR == OUT code); IN_SEL = (FIFOADR == IN code). Other codes select neither endpoint.
- Read side:
  - FIFO_DATA_OE = !SLOE && OUT_SEL, combinational.
  - FIFO_DATA_OUT = OUT head word when OE, else 16'h0000.
  - An IFCLK edge with !SLRD && OUT_SEL && not empty pops the head; the next word appears the following cycle.
  - Any number of back-to-back pops is allowed.
- Write side:
  - An edge with !SLWR && IN_SEL && FLAGB stores FIFO_DATA_IN at wr_ptr.
  - Uncommitted count increments. On reaching PKT_WORDS, the packet commits and that word gets last=1.
- PKTEND:
  - An edge with !PKTEND && IN_SEL and uncommitted count > 0 commits the uncommitted words and marks the final one last=1.
  - PKTEND together with SLWR in the same cycle includes the written word and marks it last.
  - PKTEND with count 0 (zero-length packet) is accepted and ignored.
- Flags: FLAGB and FLAGC are registered and reflect buffer state after the current edge (1-cycle latency).
  - FLAGB = total IN words (committed + uncommitted) < IN depth.
  - FLAGC = OUT count > 0.
- Host side:
  - host_wr_en while host_full is ignored and sets no error.
  - host_rd_en pops only committed words; host_rd_en while host_empty is ignored.
  - Host pop and device write in the same cycle are both honored.
- Pointers are binary and wrap modulo depth. Counts are one bit wider than the pointers, so a full buffer is distinguishable from empty.
- proto_error bits, all sticky until RESET:
  - [0] SLRD asserted while OUT empty.
  - [1] SLWR asserted while FLAGB=0.
  - [2] SLRD asserted with !OUT_SEL or with SLOE high.
  - [3] SLWR and SLRD asserted in the same cycle.
- Erroneous strobes do not change buffer state.

Optional Feature:
- SFIFO_EMU_FLAG_DELAY_EN: when defined, FLAGB and FLAGC pass through one additional register stage (2-cycle latency), matching real controller flag lag.
- Errors [0]/[1] are then judged against the true buffer state, not the delayed flags.
- When undefined, flags have 1-cycle latency as above.

Test Plan:
- Reset, then host writes 3 words 0x1111/0x2222/0x3333; FIFOADR=2'b10, SLOE=0, SLRD=0 for 3 cycles → FIFO_DATA_OUT shows 0x1111, 0x2222, 0x3333 on consecutive cycles; FLAGC drops 1 cycle after the last pop; proto_error=0.
- FIFOADR=2'b00, SLWR=0 for 256 cycles with data 0..255 → host_empty falls 1 cycle after the 256th write; host reads 0..255 with host_last=1 only on 255.
- 5 writes, then PKTEND=0 alone → 5-word packet committed, host_last on the 5th word. Repeat with PKTEND coincident with the 5th SLWR → same result.
- Fill IN with 512 words without host reads → FLAGB=0; one more SLWR sets proto_error[1], data unchanged; one host_rd_en → FLAGB returns to 1.
- SLRD with OUT empty → proto_error[0]. SLRD with FIFOADR=2'b00 → proto_error[2].
- RESET asserted mid-packet after 100 uncommitted writes → next cycle host_empty=1, FLAGB=1, FLAGC=0, all errors clear.
